usrt_rx_deframer: RTL and testbench
===================================

Name: usrt_rx_deframer

Overview:
- Receive-side stage of the APB–USRT bridge. Sits between the serial line from the peer (`Tx`) and the APB read-data holding path.
- Samples `Tx` on each baud tick and checks an 11-bit frame: 1 start, 8 data LSB-first, 1 parity, 1 stop.
- Delivers good bytes through a single-entry valid/ack holding register.
- Drops bad frames and flags them with single-cycle error pulses.

Parameters:
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.
- DATA_BITS, 8, number of data bits per frame. Only the value 8 is supported.

Ports:
- pClk  in  1  system clock; the only clock in the block.
- pReset  in  1  synchronous, active-low reset.
- uRst  in  1  synchronous, active-high soft clear from the transfer coordinator. Same effect as reset; pReset has priority.
- uClk  in  1  baud tick from the baud generator. One pClk-wide pulse per bit period. Logic acts only on cycles where uClk=1.
- Tx  in  1  serial line, idle high. Driven in the pClk domain, so no synchronizer is used.
- data  out  8  received byte; valid while dataValid=1.
- dataValid  out  1  holding register contains an unconsumed byte.
- dataAck  in  1  consumer takes data; honoured only when dataValid=1.
- parityErr  out  1  one-cycle pulse: frame dropped, parity mismatch.
- frameErr  out  1  one-cycle pulse: frame dropped, stop bit sampled 0.
- overrun  out  1  one-cycle pulse: good frame dropped because the holding register was still full.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (pReset=0, or uRst=1) at a clock edge:
  - state=IDLE, shift register=0, bit counter=0.
  - data=8'h00, dataValid=0; all pulse outputs 0; busy=0.
- FSM states IDLE, DATA, PARITY, STOP, BREAK. Transitions happen only on cycles with uClk=1; otherwise all state holds.
  - IDLE: if Tx=0 → DATA and bit counter cleared. Otherwise stay.
  - DATA: shift Tx in LSB-first; counter++. After the 8th data tick → PARITY.
  - PARITY: capture Tx as rxPar → STOP.
  - STOP, with calc = (XOR of the 8 data bits) XOR PARITY_ODD:
    - Tx=1 and rxPar==calc: good frame → IDLE.
    - Tx=1 and rxPar!=calc: parityErr pulse → IDLE.
    - Tx=0: frameErr pulse, plus parityErr if parity also mismatched → BREAK.
  - BREAK: stay until a tick samples Tx=1 → IDLE. That tick is not treated as a start bit.
- Back-to-back frames: the tick after the stop-bit tick may carry the next start bit. No idle bit is required.
- Output latency:
  - dataValid, data and all error pulses update on the pClk edge of the stop-bit tick.
  - They are therefore visible in the following cycle.
  - Pulses last exactly one pClk cycle.
- Holding register, evaluated at the stop-bit tick when the frame is good:
  - dataValid=0: load data, set dataValid=1.
  - dataValid=1 and dataAck=1 in the same cycle: load the new byte; dataValid stays 1; no overrun.
  - dataValid=1 and dataAck=0: drop the new byte; data is unchanged; overrun pulse.
- dataAck with dataValid=1 and no frame completing: dataValid=0 next cycle; data holds its last value.
- dataAck with dataValid=0 is ignored.
- A dropped frame never modifies data or dataValid.
- uClk asserted on consecutive pClk cycles: each cycle counts as a tick. Not a legal stimulus, but the behaviour must stay deterministic.
- Reset or uRst mid-frame: the partial frame is discarded with no pulses, and the held byte is cleared.

Decomposition:
- Package usrt_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP, BREAK);
  - FRAME_BITS=11 and DATA_BITS=8;
  - the line levels START_LVL=0, STOP_LVL=1, IDLE_LVL=1;
  - a parity function (8-bit, odd flag) → bit, shared with the serializer.
- One natural sub-module: usrt_rx_hold, the single-entry valid/ack holding register with overrun detection.
- The FSM and shift register stay in the top module.

Test Plan:
- 0xA5, even parity. Per-tick Tx = 0,1,0,1,0,0,1,0,1,0,1. Expect data=8'hA5 and dataValid=1 one cycle after the stop tick; no pulses.
- 0x01 with parity bit sent as 0 (even parity needs 1). Expect a parityErr pulse; dataValid stays 0; data stays 0x00.
- 0x3C with stop bit 0, Tx held 0 for 3 more ticks, then 1, then a valid 0x7E frame. Expect a frameErr pulse, no false start while in BREAK, then data=8'h7E.
- Send 0x11 without ack, then 0x22. Expect an overrun pulse at the second stop tick; data stays 8'h11. Repeat with dataAck on the stop-tick cycle: expect data=8'h22, dataValid stays 1, no overrun.
- Two back-to-back frames 0x55 then 0xAA with no idle bit, acked between them. Expect both bytes delivered in order.
- uRst=1 after 4 data bits of a frame, then a clean 0x0F frame. Expect busy=0 the next cycle, no pulses from the aborted frame, then data=8'h0F.

Source files
------------

// File: rtl/usrt_rx_deframer_pkg.sv
// Shared USRT receive definitions: frame geometry, line levels, FSM states
// and the parity helper also used by the serializer.
package usrt_pkg;

   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = 8;

   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DATA   = 3'd1,
      PARITY = 3'd2,
      STOP   = 3'd3,
      BREAK  = 3'd4
   } rx_state_e;

   // Parity bit that makes the 9-bit group even (odd=0) or odd (odd=1).
   function automatic logic calc_parity(input logic [7:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/usrt_rx_deframer_if.sv
// Valid/ack holding-register bus between the receiver and the APB read path.
interface usrt_rx_deframer_if;

   logic [7:0] data;
   logic       dataValid;
   logic       dataAck;

   modport master (
      output data,
      output dataValid,
      input  dataAck
   );

   modport slave (
      input  data,
      input  dataValid,
      output dataAck
   );

endinterface

// File: rtl/usrt_rx_deframer_hold.sv
// Single-entry holding register for received bytes; a good frame arriving
// while the entry is still full and not being acked is dropped as an overrun.
module usrt_rx_hold (
   input  logic                      pClk,
   input  logic                      pReset,
   input  logic                      uRst,
   input  logic                      i_load,
   input  logic [7:0]                i_byte,
   usrt_rx_deframer_if.master        bus,
   output logic                      o_overrun
);

   logic [7:0] r_data;
   logic       r_valid;
   logic       r_overrun;

   // Holding register state: load, replace-on-ack, drop-on-full, consume.
   always_ff @(posedge pClk) begin
      if (!pReset || uRst) begin
         r_data    <= 8'h00;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (i_load) begin
            if (!r_valid || bus.dataAck) begin
               r_data  <= i_byte;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && bus.dataAck) begin
            r_valid <= 1'b0;
         end else begin
            r_valid <= r_valid;
         end
      end
   end

   assign bus.data      = r_data;
   assign bus.dataValid = r_valid;
   assign o_overrun     = r_overrun;

endmodule

// File: rtl/usrt_rx_deframer.sv
// USRT receive deframer: samples Tx on baud ticks, checks start/parity/stop
// of an 11-bit frame and hands good bytes to the holding register.
module usrt_rx_deframer #(
   parameter bit PARITY_ODD = 1'b0,
   parameter int DATA_BITS  = 8
) (
   input  logic                      pClk,
   input  logic                      pReset,
   input  logic                      uRst,
   input  logic                      uClk,
   input  logic                      Tx,
   usrt_rx_deframer_if.master        rx_bus,
   output logic                      parityErr,
   output logic                      frameErr,
   output logic                      overrun,
   output logic                      busy
);
   import usrt_pkg::*;

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   rx_state_e  r_state,      w_state_nxt;
   logic [7:0] r_shift,      w_shift_nxt;
   logic [2:0] r_cnt,        w_cnt_nxt;
   logic       r_rx_par,     w_rx_par_nxt;
   logic       r_parity_err, w_parity_err_nxt;
   logic       r_frame_err,  w_frame_err_nxt;
   logic       w_load;
   logic       w_par_bad;

   assign w_par_bad = (r_rx_par != calc_parity(r_shift, PARITY_ODD));

   // Next-state, shift and error-pulse decode; everything holds off-tick.
   always_comb begin
      w_state_nxt      = r_state;
      w_shift_nxt      = r_shift;
      w_cnt_nxt        = r_cnt;
      w_rx_par_nxt     = r_rx_par;
      w_parity_err_nxt = 1'b0;
      w_frame_err_nxt  = 1'b0;
      w_load           = 1'b0;
      if (uClk) begin
         case (r_state)
            IDLE: begin
               if (Tx == START_LVL) begin
                  w_state_nxt = DATA;
                  w_cnt_nxt   = 3'd0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
            DATA: begin
               w_shift_nxt = {Tx, r_shift[7:1]};
               w_cnt_nxt   = r_cnt + 3'd1;
               if (r_cnt == LAST_BIT) begin
                  w_state_nxt = PARITY;
               end else begin
                  w_state_nxt = DATA;
               end
            end
            PARITY: begin
               w_rx_par_nxt = Tx;
               w_state_nxt  = STOP;
            end
            STOP: begin
               if (Tx == STOP_LVL) begin
                  w_state_nxt = IDLE;
                  if (w_par_bad) begin
                     w_parity_err_nxt = 1'b1;
                  end else begin
                     w_load = 1'b1;
                  end
               end else begin
                  // Low stop bit: line may be in a break, wait for it to rise.
                  w_state_nxt      = BREAK;
                  w_frame_err_nxt  = 1'b1;
                  w_parity_err_nxt = w_par_bad;
               end
            end
            BREAK: begin
               if (Tx == STOP_LVL) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = BREAK;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // FSM, shift register and error-pulse registers.
   always_ff @(posedge pClk) begin
      if (!pReset || uRst) begin
         r_state      <= IDLE;
         r_shift      <= 8'h00;
         r_cnt        <= 3'd0;
         r_rx_par     <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_cnt        <= w_cnt_nxt;
         r_rx_par     <= w_rx_par_nxt;
         r_parity_err <= w_parity_err_nxt;
         r_frame_err  <= w_frame_err_nxt;
      end
   end

   usrt_rx_hold u_hold (
      .pClk      (pClk),
      .pReset    (pReset),
      .uRst      (uRst),
      .i_load    (w_load),
      .i_byte    (w_shift_nxt),
      .bus       (rx_bus),
      .o_overrun (overrun)
   );

   assign parityErr = r_parity_err;
   assign frameErr  = r_frame_err;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_usrt_rx_deframer.sv
// Self-checking bench for usrt_rx_deframer: scoreboard of delivered bytes
// plus per-scenario pulse/status checks.
module tb_usrt_rx_deframer;
   import usrt_pkg::*;

   logic pClk = 1'b0;
   logic pReset, uRst, uClk, Tx;
   logic parityErr, frameErr, overrun, busy;

   int checks = 0;
   int errors = 0;
   int n_par = 0;
   int n_frm = 0;
   int n_ovr = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

   usrt_rx_deframer_if rx_bus();

   usrt_rx_deframer #(.PARITY_ODD(1'b0), .DATA_BITS(8)) dut (
      .pClk      (pClk),
      .pReset    (pReset),
      .uRst      (uRst),
      .uClk      (uClk),
      .Tx        (Tx),
      .rx_bus    (rx_bus),
      .parityErr (parityErr),
      .frameErr  (frameErr),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 pClk = ~pClk;

   // Pulses are seen at the edge following the one that raised them.
   always @(posedge pClk) begin
      if (parityErr === 1'b1) n_par <= n_par + 1;
      if (frameErr === 1'b1)  n_frm <= n_frm + 1;
      if (overrun === 1'b1)   n_ovr <= n_ovr + 1;
   end

   task automatic tick(input logic b, input logic ack);
      repeat (3) @(negedge pClk);
      Tx = b;
      uClk = 1'b1;
      rx_bus.dataAck = ack;
      @(negedge pClk);
      uClk = 1'b0;
      rx_bus.dataAck = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_ok,
                             input logic stop, input logic ack_stop);
      logic p;
      logic [10:0] f;
      p = 1'b0;
      for (int i = 0; i < 8; i++) p = p ^ b[i];
      if (!par_ok) p = ~p;
      f = {stop, p, b, START_LVL};
      for (int i = 0; i < FRAME_BITS; i++)
         tick(f[i], (i == FRAME_BITS - 1) ? ack_stop : 1'b0);
   endtask

   task automatic ack_cycle();
      @(negedge pClk);
      rx_bus.dataAck = 1'b1;
      @(negedge pClk);
      rx_bus.dataAck = 1'b0;
   endtask

   task automatic test_reset();
      pReset = 1'b0;
      repeat (3) @(negedge pClk);
      checks++;
      if (rx_bus.data !== 8'h00 || rx_bus.dataValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold got data=%h valid=%b exp 00/0", rx_bus.data, rx_bus.dataValid);
      end
      checks++;
      if ({parityErr, frameErr, overrun, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 0000", {parityErr, frameErr, overrun, busy});
      end
      pReset = 1'b1;
   endtask

   task automatic test_good();
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
      exp_b = exp_q.pop_front();
      checks++;
      if (rx_bus.dataValid !== 1'b1 || rx_bus.data !== exp_b) begin
         errors++;
         $display("FAIL good_data got %h/%b exp %h/1", rx_bus.data, rx_bus.dataValid, exp_b);
      end
      checks++;
      if ({parityErr, frameErr, overrun} !== 3'b000) begin
         errors++;
         $display("FAIL good_pulses got %b exp 000", {parityErr, frameErr, overrun});
      end
      ack_cycle();
      checks++;
      if (rx_bus.dataValid !== 1'b0 || rx_bus.data !== 8'hA5) begin
         errors++;
         $display("FAIL ack_clear got %h/%b exp a5/0", rx_bus.data, rx_bus.dataValid);
      end
   endtask

   task automatic test_parity();
      test_reset();
      send_frame(8'h01, 1'b0, 1'b1, 1'b0);
      checks++;
      if (parityErr !== 1'b1 || frameErr !== 1'b0) begin
         errors++;
         $display("FAIL par_pulse got p=%b f=%b exp 1/0", parityErr, frameErr);
      end
      checks++;
      if (rx_bus.dataValid !== 1'b0 || rx_bus.data !== 8'h00) begin
         errors++;
         $display("FAIL par_drop got %h/%b exp 00/0", rx_bus.data, rx_bus.dataValid);
      end
      @(negedge pClk);
      checks++;
      if (parityErr !== 1'b0) begin
         errors++;
         $display("FAIL par_width got %b exp 0", parityErr);
      end
   endtask

   task automatic test_break();
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      checks++;
      if (frameErr !== 1'b1 || parityErr !== 1'b0 || rx_bus.dataValid !== 1'b0) begin
         errors++;
         $display("FAIL brk_pulse got f=%b p=%b v=%b exp 1/0/0", frameErr, parityErr, rx_bus.dataValid);
      end
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL brk_hold got busy=%b exp 1", busy);
      end
      tick(IDLE_LVL, 1'b0);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL brk_exit got busy=%b exp 0", busy);
      end
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
      exp_b = exp_q.pop_front();
      checks++;
      if (rx_bus.dataValid !== 1'b1 || rx_bus.data !== exp_b) begin
         errors++;
         $display("FAIL brk_next got %h/%b exp %h/1", rx_bus.data, rx_bus.dataValid, exp_b);
      end
      ack_cycle();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      checks++;
      if (frameErr !== 1'b1 || parityErr !== 1'b1) begin
         errors++;
         $display("FAIL brk_both got f=%b p=%b exp 1/1", frameErr, parityErr);
      end
      tick(IDLE_LVL, 1'b0);
   endtask

   task automatic test_overrun();
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, 1'b1, 1'b0);
      exp_b = exp_q.pop_front();
      checks++;
      if (rx_bus.data !== exp_b || rx_bus.dataValid !== 1'b1) begin
         errors++;
         $display("FAIL ovr_first got %h/%b exp %h/1", rx_bus.data, rx_bus.dataValid, exp_b);
      end
      send_frame(8'h22, 1'b1, 1'b1, 1'b0);
      checks++;
      if (overrun !== 1'b1 || rx_bus.data !== 8'h11 || rx_bus.dataValid !== 1'b1) begin
         errors++;
         $display("FAIL ovr_drop got o=%b %h/%b exp 1 11/1", overrun, rx_bus.data, rx_bus.dataValid);
      end
      @(negedge pClk);
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_width got %b exp 0", overrun);
      end
      exp_q.push_back(8'h22);
      send_frame(8'h22, 1'b1, 1'b1, 1'b1);
      exp_b = exp_q.pop_front();
      checks++;
      if (overrun !== 1'b0 || rx_bus.data !== exp_b || rx_bus.dataValid !== 1'b1) begin
         errors++;
         $display("FAIL ovr_ackload got o=%b %h/%b exp 0 %h/1", overrun, rx_bus.data, rx_bus.dataValid, exp_b);
      end
      ack_cycle();
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, 1'b1, 1'b0);
      exp_b = exp_q.pop_front();
      checks++;
      if (rx_bus.data !== exp_b || rx_bus.dataValid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first got %h/%b exp %h/1", rx_bus.data, rx_bus.dataValid, exp_b);
      end
      ack_cycle();
      checks++;
      if (rx_bus.dataValid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ack got %b exp 0", rx_bus.dataValid);
      end
      exp_q.push_back(8'hAA);
      send_frame(8'hAA, 1'b1, 1'b1, 1'b0);
      exp_b = exp_q.pop_front();
      checks++;
      if (rx_bus.data !== exp_b || rx_bus.dataValid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second got %h/%b exp %h/1", rx_bus.data, rx_bus.dataValid, exp_b);
      end
      ack_cycle();
   endtask

   task automatic test_urst();
      int p0, f0, o0;
      logic [7:0] part;
      p0 = n_par; f0 = n_frm; o0 = n_ovr;
      part = 8'hF3;
      tick(START_LVL, 1'b0);
      for (int i = 0; i < 4; i++) tick(part[i], 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL urst_busy_pre got %b exp 1", busy);
      end
      @(negedge pClk);
      uRst = 1'b1;
      @(negedge pClk);
      uRst = 1'b0;
      checks++;
      if (busy !== 1'b0 || rx_bus.dataValid !== 1'b0 || rx_bus.data !== 8'h00) begin
         errors++;
         $display("FAIL urst_clear got busy=%b %h/%b exp 0 00/0", busy, rx_bus.data, rx_bus.dataValid);
      end
      exp_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
      exp_b = exp_q.pop_front();
      checks++;
      if (rx_bus.data !== exp_b || rx_bus.dataValid !== 1'b1) begin
         errors++;
         $display("FAIL urst_next got %h/%b exp %h/1", rx_bus.data, rx_bus.dataValid, exp_b);
      end
      repeat (2) @(negedge pClk);
      checks++;
      if (n_par != p0 || n_frm != f0 || n_ovr != o0) begin
         errors++;
         $display("FAIL urst_pulses got %0d/%0d/%0d exp %0d/%0d/%0d", n_par, n_frm, n_ovr, p0, f0, o0);
      end
   endtask

   initial begin
      pReset = 1'b0;
      uRst = 1'b0;
      uClk = 1'b0;
      Tx = IDLE_LVL;
      rx_bus.dataAck = 1'b0;
      test_reset();
      test_good();
      test_parity();
      test_break();
      test_overrun();
      test_back_to_back();
      test_urst();
      repeat (3) @(negedge pClk);
      checks++;
      if (n_par != 2 || n_frm != 2 || n_ovr != 1) begin
         errors++;
         $display("FAIL pulse_totals got %0d/%0d/%0d exp 2/2/1", n_par, n_frm, n_ovr);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got %0d exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
